// File: rtl/rd_serial_tx_pkg.sv
// +------------------------------------------------------------------+
// | rd_serial_tx_pkg : shared RD serial-link types and constants     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package rd_serial_tx_pkg;

  typedef enum logic [1:0] {
    PAT_RAMP  = 2'd0,
    PAT_CONST = 2'd1,
    PAT_LFSR  = 2'd2,
    PAT_RSVD  = 2'd3
  } rd_pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } rd_state_e;

  typedef struct packed {
    logic [11:0] lane1;
    logic [11:0] lane0;
  } rd_word_t;

  localparam int unsigned c_data_bits  = 12;
  localparam int unsigned c_frame_len  = 13;
  localparam int unsigned c_max_words  = 2048;
  localparam int unsigned c_gap_cycles = 2;

  // x^12+x^6+x^4+x+1 expressed as a mask over state bits 11,5,3,0
  localparam logic [11:0] c_lfsr_seed = 12'hACE;
  localparam logic [11:0] c_lfsr_taps = 12'b1000_0010_1001;

  function automatic logic odd_parity(input logic [11:0] d);
    return ~(^d);
  endfunction

  function automatic logic [11:0] bit_rev12(input logic [11:0] d);
    logic [11:0] r;
    for (int k = 0; k < 12; k++) begin
      r[k] = d[11-k];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rd_pattern_gen.sv
// +------------------------------------------------------------------+
// | rd_pattern_gen : ramp / constant / LFSR word source for RD lanes |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module rd_pattern_gen
  import rd_serial_tx_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        SEED,
  input  logic        ADVANCE,
  input  logic [11:0] WORD_IDX,
  input  logic [1:0]  PATTERN,
  input  logic [23:0] CONST_DATA,
  output rd_word_t    WORD
);

  logic [11:0] r_lfsr;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_lfsr <= c_lfsr_seed;
    end else if (SEED) begin
      r_lfsr <= c_lfsr_seed;
    end else if (ADVANCE) begin
      r_lfsr <= {r_lfsr[10:0], ^(r_lfsr & c_lfsr_taps)};
    end
  end

  // Reserved pattern code falls through to the ramp default.
  always_comb begin
    WORD = '{lane1: ~WORD_IDX, lane0: WORD_IDX};
    case (PATTERN)
      PAT_CONST: WORD = '{lane1: CONST_DATA[23:12], lane0: CONST_DATA[11:0]};
      PAT_LFSR:  WORD = '{lane1: bit_rev12(r_lfsr), lane0: r_lfsr};
      default:   ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rd_serial_tx.sv
// +------------------------------------------------------------------+
// | rd_serial_tx : triggered two-lane RD serial transmitter          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module rd_serial_tx
  import rd_serial_tx_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        TRIG_IN,
  input  logic [11:0] NWORDS,
  input  logic [15:0] DELAY,
  input  logic [1:0]  PATTERN,
  input  logic [23:0] CONST_DATA,
  input  logic [1:0]  PERR_INJECT,
  output logic        SERIAL_DATA0_OUT,
  output logic        SERIAL_DATA1_OUT,
  output logic        ENABLE_XFR_OUT,
  output logic        BUSY,
  output logic        DONE,
  output logic [7:0]  TRIG_DROPPED
);

  rd_state_e   r_state;
  rd_state_e   w_state_nxt;

  logic        r_trig_d;
  logic [15:0] r_wait_cnt;
  logic [3:0]  r_bit_cnt;
  logic [11:0] r_word_idx;
  logic [11:0] r_nwords;
  logic [1:0]  r_gap_cnt;
  logic [1:0]  r_perr;
  logic [11:0] r_sh0;
  logic [11:0] r_sh1;
  logic        r_par0;
  logic        r_par1;
  logic [7:0]  r_dropped;

  logic        w_trig_edge;
  logic        w_accept;
  logic        w_load;
  logic        w_last_bit;
  logic        w_more_words;
  rd_word_t    w_word;

  assign w_trig_edge  = TRIG_IN & ~r_trig_d;
  assign w_last_bit   = (r_bit_cnt == 4'(c_frame_len - 1));
  // r_word_idx counts words already loaded, so it doubles as the pattern index.
  assign w_more_words = (r_word_idx != r_nwords);
  assign TRIG_DROPPED = r_dropped;

  rd_pattern_gen u_pattern_gen (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .SEED       (w_accept),
    .ADVANCE    (w_load),
    .WORD_IDX   (r_word_idx),
    .PATTERN    (PATTERN),
    .CONST_DATA (CONST_DATA),
    .WORD       (w_word)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_accept         = 1'b0;
    w_load           = 1'b0;
    ENABLE_XFR_OUT   = 1'b0;
    SERIAL_DATA0_OUT = 1'b0;
    SERIAL_DATA1_OUT = 1'b0;
    BUSY             = (r_state != ST_IDLE);
    DONE             = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trig_edge) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt == 16'd0) begin
          if (r_nwords == 12'd0) begin
            w_state_nxt = ST_GAP;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        ENABLE_XFR_OUT   = 1'b1;
        SERIAL_DATA0_OUT = w_last_bit ? r_par0 : r_sh0[11];
        SERIAL_DATA1_OUT = w_last_bit ? r_par1 : r_sh1[11];
        if (w_last_bit) begin
          if (w_more_words) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        DONE = (r_gap_cnt == 2'd0);
        if (r_gap_cnt == 2'(c_gap_cycles - 1)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_trig_d   <= 1'b0;
      r_wait_cnt <= 16'd0;
      r_bit_cnt  <= 4'd0;
      r_word_idx <= 12'd0;
      r_nwords   <= 12'd0;
      r_gap_cnt  <= 2'd0;
      r_perr     <= 2'b00;
      r_sh0      <= 12'd0;
      r_sh1      <= 12'd0;
      r_par0     <= 1'b0;
      r_par1     <= 1'b0;
      r_dropped  <= 8'd0;
    end else begin
      r_trig_d <= TRIG_IN;

      if (w_trig_edge && (r_state != ST_IDLE) && (r_dropped != 8'hFF)) begin
        r_dropped <= r_dropped + 8'd1;
      end

      if (w_accept) begin
        r_wait_cnt <= DELAY;
        r_nwords   <= (NWORDS > 12'(c_max_words)) ? 12'(c_max_words) : NWORDS;
        r_perr     <= PERR_INJECT;
        r_word_idx <= 12'd0;
      end else if ((r_state == ST_WAIT) && (r_wait_cnt != 16'd0)) begin
        r_wait_cnt <= r_wait_cnt - 16'd1;
      end

      // Word is captured on the same edge that starts driving its MSB.
      if (w_load) begin
        r_sh0      <= w_word.lane0;
        r_sh1      <= w_word.lane1;
        r_par0     <= odd_parity(w_word.lane0) ^ r_perr[0];
        r_par1     <= odd_parity(w_word.lane1) ^ r_perr[1];
        r_bit_cnt  <= 4'd0;
        r_word_idx <= r_word_idx + 12'd1;
      end else if (r_state == ST_SEND) begin
        r_sh0     <= {r_sh0[10:0], 1'b0};
        r_sh1     <= {r_sh1[10:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end

      if ((w_state_nxt == ST_GAP) && (r_state != ST_GAP)) begin
        r_gap_cnt <= 2'd0;
      end else if (r_state == ST_GAP) begin
        r_gap_cnt <= r_gap_cnt + 2'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rd_serial_tx.sv
// +------------------------------------------------------------------+
// | tb_rd_serial_tx : randomized bench with behavioural RD receiver  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_rd_serial_tx;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        TRIG_IN = 1'b0;
  logic [11:0] NWORDS = 12'd0;
  logic [15:0] DELAY = 16'd0;
  logic [1:0]  PATTERN = 2'd0;
  logic [23:0] CONST_DATA = 24'd0;
  logic [1:0]  PERR_INJECT = 2'd0;
  logic        SERIAL_DATA0_OUT;
  logic        SERIAL_DATA1_OUT;
  logic        ENABLE_XFR_OUT;
  logic        BUSY;
  logic        DONE;
  logic [7:0]  TRIG_DROPPED;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp0[$];
  logic [11:0] exp1[$];
  logic        rx0[$];
  logic        rx1[$];

  always #5 CLK = ~CLK;

  rd_serial_tx dut (
    .CLK              (CLK),
    .RSTN             (RSTN),
    .TRIG_IN          (TRIG_IN),
    .NWORDS           (NWORDS),
    .DELAY            (DELAY),
    .PATTERN          (PATTERN),
    .CONST_DATA       (CONST_DATA),
    .PERR_INJECT      (PERR_INJECT),
    .SERIAL_DATA0_OUT (SERIAL_DATA0_OUT),
    .SERIAL_DATA1_OUT (SERIAL_DATA1_OUT),
    .ENABLE_XFR_OUT   (ENABLE_XFR_OUT),
    .BUSY             (BUSY),
    .DONE             (DONE),
    .TRIG_DROPPED     (TRIG_DROPPED)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] rev12(input logic [11:0] d);
    logic [11:0] r;
    for (int k = 0; k < 12; k++) r[k] = d[11-k];
    return r;
  endfunction

  // Fibonacci step from the polynomial exponents: feedback is the XOR of stage(e-1).
  function automatic logic [11:0] lfsr_next(input logic [11:0] s);
    int   taps[4] = '{12, 6, 4, 1};
    logic fb = 1'b0;
    foreach (taps[t]) fb ^= s[taps[t]-1];
    return {s[10:0], fb};
  endfunction

  task automatic run_xfer(input string name, input int nw, input int dly, input logic [1:0] pat,
                          input logic [23:0] cd, input logic [1:0] perr,
                          input int drop_mode, input int abort_at);
    int n_eff, c, limit, en_cnt, first_en, last_en, gaps, done_cnt, done_at;
    int bad0, bad1, pe0, pe1;
    logic [11:0] s, d0, d1;
    logic p0, p1;

    n_eff = (nw > 2048) ? 2048 : nw;
    exp0.delete(); exp1.delete(); rx0.delete(); rx1.delete();
    s = 12'hACE;
    for (int i = 0; i < n_eff; i++) begin
      case (pat)
        2'd1:    begin exp0.push_back(cd[11:0]); exp1.push_back(cd[23:12]); end
        2'd2:    begin exp0.push_back(s); exp1.push_back(rev12(s)); s = lfsr_next(s); end
        default: begin exp0.push_back(12'(i)); exp1.push_back(~12'(i)); end
      endcase
    end

    @(negedge CLK);
    NWORDS = 12'(nw); DELAY = 16'(dly); PATTERN = pat; CONST_DATA = cd; PERR_INJECT = perr;
    TRIG_IN = 1'b1;
    RSTN = 1'b1;
    @(negedge CLK);
    TRIG_IN = 1'b0;

    limit = dly + 13 * n_eff + 40;
    en_cnt = 0; first_en = -1; last_en = -1; gaps = 0; done_cnt = 0; done_at = -1; c = 0;
    while (BUSY && c < limit) begin
      if (ENABLE_XFR_OUT) begin
        if (first_en < 0) first_en = c;
        else if (last_en != c - 1) gaps++;
        last_en = c;
        en_cnt++;
        rx0.push_back(SERIAL_DATA0_OUT);
        rx1.push_back(SERIAL_DATA1_OUT);
      end else if (SERIAL_DATA0_OUT || SERIAL_DATA1_OUT) begin
        gaps++;
      end
      if (DONE) begin done_cnt++; done_at = c; end
      if (abort_at >= 0 && en_cnt == abort_at + 1) begin
        RSTN = 1'b0;
        #1;
        check({name, "/rst_enable"}, ENABLE_XFR_OUT, 0);
        check({name, "/rst_busy"}, BUSY, 0);
        check({name, "/rst_lanes"}, {SERIAL_DATA1_OUT, SERIAL_DATA0_OUT}, 0);
        check({name, "/rst_dropped"}, TRIG_DROPPED, 0);
        repeat (4) begin
          @(negedge CLK);
          if (DONE) done_cnt++;
        end
        check({name, "/rst_no_done"}, done_cnt, 0);
        TRIG_IN = 1'b0;
        return;
      end
      case (drop_mode)
        1:       TRIG_IN = (ENABLE_XFR_OUT && en_cnt == 5) || DONE;
        2:       TRIG_IN = c[0];
        default: ;
      endcase
      @(negedge CLK);
      c++;
    end
    TRIG_IN = 1'b0;

    check({name, "/finished"}, BUSY, 0);
    check({name, "/enable_cycles"}, en_cnt, 13 * n_eff);
    check({name, "/done_pulses"}, done_cnt, 1);
    check({name, "/gaps_or_idle_data"}, gaps, 0);
    if (n_eff > 0) begin
      check({name, "/first_enable"}, first_en, dly + 1);
      check({name, "/done_cycle"}, done_at, first_en + 13 * n_eff);
    end else begin
      check({name, "/done_cycle"}, done_at, dly + 1);
    end

    bad0 = 0; bad1 = 0; pe0 = 0; pe1 = 0;
    if (rx0.size() >= 13 * n_eff) begin
      for (int w = 0; w < n_eff; w++) begin
        for (int b = 0; b < 12; b++) begin
          d0[11-b] = rx0[13*w+b];
          d1[11-b] = rx1[13*w+b];
        end
        p0 = rx0[13*w+12];
        p1 = rx1[13*w+12];
        if (d0 != exp0[w]) bad0++;
        if (d1 != exp1[w]) bad1++;
        if (($countones({d0, p0}) % 2) == 0) pe0++;
        if (($countones({d1, p1}) % 2) == 0) pe1++;
      end
    end
    check({name, "/lane0_data_errs"}, bad0, 0);
    check({name, "/lane1_data_errs"}, bad1, 0);
    check({name, "/lane0_parity_errs"}, pe0, perr[0] ? n_eff : 0);
    check({name, "/lane1_parity_errs"}, pe1, perr[1] ? n_eff : 0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("reset/enable", ENABLE_XFR_OUT, 0);
    check("reset/busy", BUSY, 0);
    check("reset/done", DONE, 0);
    check("reset/lanes", {SERIAL_DATA1_OUT, SERIAL_DATA0_OUT}, 0);
    check("reset/dropped", TRIG_DROPPED, 0);
    RSTN = 1'b1;
    @(negedge CLK);

    run_xfer("ramp3", 3, 0, 2'd0, 24'd0, 2'b00, 0, -1);
    run_xfer("const", 2, 3, 2'd1, 24'h5A5000, 2'b01, 0, -1);
    run_xfer("lfsr", 6, 2, 2'd2, 24'd0, 2'b10, 0, -1);
    run_xfer("rsvd", 4, 1, 2'd3, 24'd0, 2'b00, 0, -1);
    check("dropped_none", TRIG_DROPPED, 0);

    run_xfer("drop", 2, 10, 2'd0, 24'd0, 2'b00, 1, -1);
    check("dropped_two", TRIG_DROPPED, 2);

    for (int r = 0; r < 8; r++) begin
      run_xfer($sformatf("rand%0d", r), $urandom_range(0, 12), $urandom_range(0, 20),
               2'($urandom_range(0, 3)), 24'($urandom), 2'($urandom_range(0, 3)), 0, -1);
    end
    check("dropped_after_rand", TRIG_DROPPED, 2);

    run_xfer("nwords0", 0, 4, 2'd0, 24'd0, 2'b00, 0, -1);
    run_xfer("saturate", 50, 10, 2'd0, 24'd0, 2'b00, 2, -1);
    check("dropped_saturated", TRIG_DROPPED, 255);

    run_xfer("nwords4095", 4095, 0, 2'd2, 24'd0, 2'b00, 0, -1);

    run_xfer("abort", 8, 0, 2'd0, 24'd0, 2'b00, 0, 5 * 13 + 7);
    // TRIG_IN held high across reset release must count as a fresh edge.
    TRIG_IN = 1'b1;
    repeat (2) @(negedge CLK);
    run_xfer("post_rst_ramp", 4, 0, 2'd0, 24'd0, 2'b00, 0, -1);
    run_xfer("post_rst_lfsr", 3, 1, 2'd2, 24'd0, 2'b00, 0, -1);
    check("dropped_post_rst", TRIG_DROPPED, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
